// File: rtl/fft_stage_scheduler.sv
// Address and strobe scheduler for an in-place radix-2 DIF FFT.
// Ping-pong banks: each stage reads bank_sel and writes ~bank_sel. Reads are
// issued as a/b pairs per butterfly. Writes replay the reads BF_LAT cycles later.
// Optional build macro FFT_BITREV_OUT_EN: last-stage writes use bit-reversed
// addresses so that the result lands in natural order.
module fft_stage_scheduler #(
    parameter int N      = 256,
    parameter int SIZE   = 8,
    parameter int BF_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            en_rd,
    output logic [SIZE-1:0] rd_ptr,
    output logic [SIZE-2:0] rd_ptr_angle,
    output logic            en_wr,
    output logic [SIZE-1:0] wr_ptr,
    output logic            bank_sel,
    output logic [SIZE-1:0] stage,
    output logic            busy,
    output logic            done_o
);

    localparam int CNT_W = $clog2(BF_LAT + 1);
    localparam logic [SIZE-2:0] J_LAST     = (SIZE-1)'(N / 2 - 1);
    localparam logic [SIZE-1:0] STAGE_LAST = SIZE'(SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BF_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, READ_A, READ_B, DRAIN, NEXT_STAGE, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-2:0]   j_q, j_d;
    logic [SIZE-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bank_q, bank_d;

    logic              en_rd_q, en_rd_d;
    logic [SIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic [SIZE-2:0]   angle_q, angle_d;
    logic              busy_q, done_q;

    logic [SIZE-2:0]   mask, pos, hi;
    logic [SIZE-1:0]   addr_a, addr_b, stride;
    logic [SIZE-1:0]   wr_in;

    logic              en_dl_q   [BF_LAT];
    logic [SIZE-1:0]   addr_dl_q [BF_LAT];

    wire abort_busy = abort && (state_q != IDLE);

    // Next-state logic for the stage / butterfly sequencing FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        j_d     = j_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = READ_A;
                    j_d     = '0;
                    stage_d = '0;
                end
            end
            READ_A: state_d = READ_B;
            READ_B: begin
                if (j_q != J_LAST) begin
                    state_d = READ_A;
                    j_d     = j_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = (stage_q == STAGE_LAST) ? DONE : NEXT_STAGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT_STAGE: begin
                state_d = READ_A;
                stage_d = stage_q + 1'b1;
                j_d     = '0;
                bank_d  = ~bank_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_busy) begin
            state_d = IDLE;
            j_d     = '0;
            stage_d = '0;
            cnt_d   = '0;
            bank_d  = 1'b0;
        end
    end

    // Butterfly addresses for the upcoming cycle; the stride mask splits j
    // into group bits (shifted up one place) and position-in-group bits.
    always_comb begin
        mask     = {(SIZE-1){1'b1}} >> stage_d;
        pos      = j_d & mask;
        hi       = j_d & ~mask;
        addr_a   = {hi, 1'b0} | {1'b0, pos};
        stride   = {1'b0, mask} + SIZE'(1);
        addr_b   = addr_a | stride;
        en_rd_d  = (state_d == READ_A) || (state_d == READ_B);
        rd_ptr_d = '0;
        angle_d  = '0;
        if (state_d == READ_A) begin
            rd_ptr_d = addr_a;
            angle_d  = pos << stage_d;
        end else if (state_d == READ_B) begin
            rd_ptr_d = addr_b;
        end
    end

`ifdef FFT_BITREV_OUT_EN
    // Last-stage write addresses are bit-reversed at the delay line entry.
    always_comb begin
        wr_in = rd_ptr_q;
        if (stage_q == STAGE_LAST) begin
            for (int i = 0; i < SIZE; i++) wr_in[i] = rd_ptr_q[SIZE-1-i];
        end
    end
`else
    // Write addresses are the read addresses, unmodified.
    always_comb wr_in = rd_ptr_q;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            j_q      <= '0;
            stage_q  <= '0;
            cnt_q    <= '0;
            bank_q   <= 1'b0;
            en_rd_q  <= 1'b0;
            rd_ptr_q <= '0;
            angle_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers update together from the values before the edge.
            state_q  <= state_d;
            j_q      <= j_d;
            stage_q  <= stage_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            en_rd_q  <= en_rd_d;
            rd_ptr_q <= rd_ptr_d;
            angle_q  <= angle_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    // Write delay line: replays the read strobe/address BF_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the delay line is reset (and flushed on abort) because stale
            // entries would otherwise emit spurious write strobes.
            for (int i = 0; i < BF_LAT; i++) begin
                en_dl_q[i]   <= 1'b0;
                addr_dl_q[i] <= '0;
            end
        end else if (abort_busy) begin
            for (int i = 0; i < BF_LAT; i++) begin
                en_dl_q[i]   <= 1'b0;
                addr_dl_q[i] <= '0;
            end
        end else begin
            en_dl_q[0]   <= en_rd_q;
            addr_dl_q[0] <= wr_in;
            for (int i = 1; i < BF_LAT; i++) begin
                en_dl_q[i]   <= en_dl_q[i-1];
                addr_dl_q[i] <= addr_dl_q[i-1];
            end
        end
    end

    assign en_rd        = en_rd_q;
    assign rd_ptr       = rd_ptr_q;
    assign rd_ptr_angle = angle_q;
    assign en_wr        = en_dl_q[BF_LAT-1];
    assign wr_ptr       = addr_dl_q[BF_LAT-1];
    assign bank_sel     = bank_q;
    assign stage        = stage_q;
    assign busy         = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Self-checking bench for fft_stage_scheduler (N=16, SIZE=4, BF_LAT=4).
// A per-cycle expectation list for one whole transform is built from the
// address arithmetic (divide/modulo) and the state-duration rules; writes are
// the read list shifted by BF_LAT. Inputs driven and outputs sampled on negedge.
module tb_fft_stage_scheduler;

    localparam int N      = 16;
    localparam int SIZE   = 4;
    localparam int BF_LAT = 4;
    localparam int TOTAL  = (SIZE-1)*(N+BF_LAT+1) + N + BF_LAT + 1;
`ifdef FFT_BITREV_OUT_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            en_rd, en_wr, bank_sel, busy, done_o;
    logic [SIZE-1:0] rd_ptr, wr_ptr, stage;
    logic [SIZE-2:0] rd_ptr_angle;

    always #5 clk = ~clk;

    fft_stage_scheduler #(.N(N), .SIZE(SIZE), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .en_rd(en_rd), .rd_ptr(rd_ptr), .rd_ptr_angle(rd_ptr_angle),
        .en_wr(en_wr), .wr_ptr(wr_ptr), .bank_sel(bank_sel), .stage(stage),
        .busy(busy), .done_o(done_o)
    );

    typedef struct {
        bit rd;
        bit is_a;
        int addr;
        int ang;
        int stg;
        bit bank;
        bit done;
    } cyc_t;

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   model_bank = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < SIZE; i++) if (v[i]) r |= 1 << (SIZE-1-i);
        return r;
    endfunction

    // One transform, cycle by cycle, from the stage/stride rules.
    function automatic void build(input bit b0);
        bit   b = b0;
        cyc_t c;
        exp_q.delete();
        for (int s = 0; s < SIZE; s++) begin
            int stride = N >> (s + 1);
            for (int j = 0; j < N/2; j++) begin
                int p = j % stride;
                int a = (j / stride) * 2 * stride + p;
                c = '{rd: 1, is_a: 1, addr: a, ang: (p << s) % (N/2), stg: s, bank: b, done: 0};
                exp_q.push_back(c);
                c = '{rd: 1, is_a: 0, addr: a + stride, ang: 0, stg: s, bank: b, done: 0};
                exp_q.push_back(c);
            end
            for (int d = 0; d < BF_LAT; d++) begin
                c = '{rd: 0, is_a: 0, addr: 0, ang: 0, stg: s, bank: b, done: 0};
                exp_q.push_back(c);
            end
            c = '{rd: 0, is_a: 0, addr: 0, ang: 0, stg: s, bank: b, done: (s == SIZE-1)};
            exp_q.push_back(c);
            if (s < SIZE-1) b = ~b;
        end
    endfunction

    task automatic check_cycle(input int k);
        cyc_t e = exp_q[k];
        int   we = 0;
        int   wa = 0;
        check($sformatf("busy@%0d", k), 32'(busy), 1);
        check($sformatf("en_rd@%0d", k), 32'(en_rd), 32'(e.rd));
        if (e.rd) check($sformatf("rd_ptr@%0d", k), 32'(rd_ptr), e.addr);
        if (e.is_a) check($sformatf("angle@%0d", k), 32'(rd_ptr_angle), e.ang);
        check($sformatf("stage@%0d", k), 32'(stage), e.stg);
        check($sformatf("bank@%0d", k), 32'(bank_sel), 32'(e.bank));
        check($sformatf("done@%0d", k), 32'(done_o), 32'(e.done));
        if (k >= BF_LAT) begin
            cyc_t w = exp_q[k-BF_LAT];
            we = w.rd;
            wa = (BITREV && w.stg == SIZE-1) ? bitrev(w.addr) : w.addr;
        end
        check($sformatf("en_wr@%0d", k), 32'(en_wr), we);
        if (we != 0) check($sformatf("wr_ptr@%0d", k), 32'(wr_ptr), wa);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"},  32'(busy), 0);
        check({tag, ".en_rd"}, 32'(en_rd), 0);
        check({tag, ".en_wr"}, 32'(en_wr), 0);
        check({tag, ".done"},  32'(done_o), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle(tag);
        check({tag, ".rd_ptr"}, 32'(rd_ptr), 0);
        check({tag, ".angle"},  32'(rd_ptr_angle), 0);
        check({tag, ".wr_ptr"}, 32'(wr_ptr), 0);
        check({tag, ".bank"},   32'(bank_sel), 0);
        check({tag, ".stage"},  32'(stage), 0);
    endtask

    // Runs one transform from a negedge; optional abort or reset at cycle index.
    task automatic run(input int abort_at, input int rst_at, input bit noise);
        int dcount = 0;
        int bcount = 0;
        build(model_bank);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            check_cycle(k);
            dcount += int'(done_o);
            bcount += int'(busy);
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_all_zero("abort");
                model_bank = 1'b0;
                for (int i = 0; i < BF_LAT + 2; i++) begin
                    @(negedge clk);
                    check_idle("post_abort");
                end
                return;
            end
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                @(negedge clk);
                check_all_zero("in_rst");
                rst_n = 1'b1;
                model_bank = 1'b0;
                @(negedge clk);
                check_all_zero("after_rst");
                return;
            end
            start = noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check_idle("end");
        check("done_pulses", dcount, 1);
        check("busy_cycles", bcount, TOTAL);
        model_bank = exp_q[TOTAL-1].bank;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("no_autostart");
        end

        // Full transform with stray start pulses while busy.
        run(-1, -1, 1'b1);
        check("final_bank", 32'(bank_sel), 1);

        // abort and start together in IDLE: stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle("abort_start");
        @(negedge clk);
        check_idle("abort_start2");

        // Abort at a random point in stage 1, then a clean full transform.
        run(N + BF_LAT + 1 + int'($urandom_range(0, N + BF_LAT)), -1, 1'b0);
        run(-1, -1, 1'b0);

        // Reset during a READ_B of stage 2, then a full transform again.
        run(-1, 2*(N + BF_LAT + 1) + 2*int'($urandom_range(0, N/2 - 1)) + 1, 1'b1);
        run(-1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_stage_scheduler.md
FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 SHALL have parameter N, default 256, FFT point count (power of two, >= 8).
REQ-002 SHALL have parameter SIZE, default 8, log2(N); address width.
REQ-003 SHALL have parameter BF_LAT, default 4, butterfly datapath latency in cycles (>= 1).
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to run a full N-point transform.
REQ-007 abort  input  1  synchronous cancel of a running transform.
REQ-008 en_rd  output  1  read strobe to the source RAM bank.
REQ-009 rd_ptr  output  SIZE  read address.
REQ-010 rd_ptr_angle  output  SIZE-1  twiddle ROM address, valid with the "a" read.
REQ-011 en_wr  output  1  write strobe to the destination RAM bank.
REQ-012 wr_ptr  output  SIZE  write address.
REQ-013 bank_sel  output  1  read bank index; writes go to ~bank_sel.
REQ-014 stage  output  SIZE bits (enough to hold 0..SIZE-1)  current stage index.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done_o  output  1  one-cycle pulse when the transform completes.

Function
REQ-017 States SHALL be IDLE, READ_A, READ_B, DRAIN, NEXT_STAGE and DONE; all outputs registered.
REQ-018 IDLE -> READ_A when start=1 and abort=0; stage=0, butterfly index j=0.
REQ-019 READ_A -> READ_B unconditionally; READ_B -> READ_A while j < N/2-1 (j increments), else -> DRAIN.
REQ-020 Address rule, stage s, stride = N>>(s+1), pos = j mod stride: a = (j/stride)*2*stride + pos, b = a + stride, twiddle = pos<<s truncated to SIZE-1 bits.
REQ-021 READ_A cycle: en_rd=1, rd_ptr=a, rd_ptr_angle=twiddle; READ_B cycle: en_rd=1, rd_ptr=b; en_rd=0 in all other states.
REQ-022 en_wr/wr_ptr SHALL replay en_rd/rd_ptr delayed exactly BF_LAT cycles (two consecutive writes, a then b, per butterfly).
REQ-023 DRAIN SHALL last exactly BF_LAT cycles; then -> NEXT_STAGE if stage < SIZE-1, else -> DONE.
REQ-024 NEXT_STAGE (1 cycle): bank_sel toggles, stage increments, j=0; -> READ_A.
REQ-025 DONE (1 cycle): done_o=1; -> IDLE; bank_sel not toggled.
REQ-026 Cycles from start-sample to done_o = (SIZE-1)*(N+BF_LAT+1) + N + BF_LAT + 1.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort=1 in any busy state SHALL force IDLE next cycle, clear en_rd, flush the write delay line (en_wr=0 next cycle), no done_o pulse, reset stage and bank_sel to 0.
REQ-029 abort and start asserted together in IDLE: abort wins, remain IDLE.

Reset
REQ-030 On rst_n=0, regardless of state: state=IDLE, en_rd=0, en_wr=0, rd_ptr=0, rd_ptr_angle=0, wr_ptr=0, bank_sel=0, stage=0, busy=0, done_o=0, delay line cleared.
REQ-031 Reset deassertion SHALL NOT start a transform; start is required.

Configuration
REQ-032 Macro FFT_BITREV_OUT_EN: when defined, writes during stage SIZE-1 SHALL use wr_ptr bit-reversed over SIZE bits (natural-order output); when undefined, wr_ptr is the unmodified delayed rd_ptr in all stages.

Verification (N=16, SIZE=4, BF_LAT=4)
REQ-033 start pulse -> stage 0 reads 0,8,1,9,...,7,15, rd_ptr_angle 0..7 on "a" reads; done_o single pulse 84 cycles after start-sample.
REQ-034 Stage 3 -> reads 0,1,2,3,...; rd_ptr_angle=0 on every "a" read; bank_sel=1 (toggled 3 times).
REQ-035 First en_wr exactly 4 cycles after first en_rd, wr_ptr=0 then 8; en_wr count per stage = 16.
REQ-036 abort mid stage 1 -> busy=0 next cycle, en_wr=0 from next cycle, no done_o, bank_sel=0; a new start then runs a full 84-cycle transform.
REQ-037 FFT_BITREV_OUT_EN defined, stage 3 butterfly j=1 -> writes to 4 and 12; undefined -> 2 and 3.
REQ-038 rst_n pulsed low during READ_B of stage 2 -> all outputs 0 immediately; start during busy -> ignored (done_o count stays 1).
